// File: rtl/lab2_proc_fetch_inst_queue.sv
// Fetch-side instruction buffer: tracks outstanding imem requests and their PCs,
// drops responses from squashed paths, and queues instructions for decode.
module lab2_proc_fetch_inst_queue #(
  parameter int NUM_ENTRIES  = 2,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_fire,
  input  logic [31:0] req_pc,
  output logic        inflight_full,
  input  logic        squash,
  input  logic        imemresp_val,
  output logic        imemresp_rdy,
  input  logic [31:0] imemresp_data,
  output logic        inst_val,
  input  logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [2:0]  imm_type
);

  localparam int QW = $clog2(NUM_ENTRIES);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] pc_rd_q, pc_rd_d;
  logic [PW-1:0] pc_wr_q, pc_wr_d;
  logic [31:0]   pc_mem_q [MAX_INFLIGHT];

  logic [QW-1:0] head_q, head_d;
  logic [QW-1:0] tail_q, tail_d;
  logic [QW:0]   count_q, count_d;
  logic [31:0]   inst_mem_q [NUM_ENTRIES];
  logic [31:0]   ipc_mem_q  [NUM_ENTRIES];

  logic q_full, resp_fire, resp_keep, deq;
  logic [PW-1:0] pc_wr_idx;

  function automatic logic [PW-1:0] pc_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign q_full        = (count_q == (QW+1)'(NUM_ENTRIES));
  assign inst_val      = (count_q != '0);
  assign inflight_full = (out_cnt_q == CW'(MAX_INFLIGHT));
  // Deliberately independent of inst_rdy so the response path never waits on decode.
  assign imemresp_rdy  = squash | (drop_cnt_q != '0) | !q_full;
  assign resp_fire     = imemresp_val & imemresp_rdy;
  assign resp_keep     = resp_fire & !squash & (drop_cnt_q == '0);
  assign deq           = inst_val & inst_rdy & !squash;
  assign pc_wr_idx     = squash ? '0 : pc_wr_q;

  always_comb begin
    out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(resp_fire);
    drop_cnt_d = drop_cnt_q;
    pc_rd_d    = pc_rd_q;
    pc_wr_d    = pc_wr_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (squash) begin
      // Every request issued before the redirect is now on the wrong path.
      drop_cnt_d = out_cnt_q - CW'(resp_fire);
      pc_rd_d    = '0;
      pc_wr_d    = req_fire ? pc_inc('0) : '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (resp_fire && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
      if (req_fire)  pc_wr_d = pc_inc(pc_wr_q);
      if (resp_keep) pc_rd_d = pc_inc(pc_rd_q);
      if (resp_keep) tail_d  = tail_q + QW'(1);
      if (deq)       head_d  = head_q + QW'(1);
      count_d = count_q + (QW+1)'(resp_keep) - (QW+1)'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      pc_rd_q    <= '0;
      pc_wr_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      pc_rd_q    <= pc_rd_d;
      pc_wr_q    <= pc_wr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pc_mem_q[pc_wr_idx] <= req_pc;
    if (resp_keep) begin
      inst_mem_q[tail_q] <= imemresp_data;
      ipc_mem_q[tail_q]  <= pc_mem_q[pc_rd_q];
    end
  end

  assign inst    = inst_val ? inst_mem_q[head_q] : '0;
  assign inst_pc = inst_val ? ipc_mem_q[head_q]  : '0;

  always_comb begin
    imm_type = 3'd7;
    if (inst_val) begin
      case (inst[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: imm_type = 3'd0;
        7'b0100011:                         imm_type = 3'd1;
        7'b1100011:                         imm_type = 3'd2;
        7'b0110111, 7'b0010111:             imm_type = 3'd3;
        7'b1101111:                         imm_type = 3'd4;
        default:                            imm_type = 3'd7;
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_proc_fetch_inst_queue.sv
// Directed bench for the fetch instruction queue with hand-computed expectations.
module tb_lab2_proc_fetch_inst_queue;

  logic        clk;
  logic        reset;
  logic        req_fire;
  logic [31:0] req_pc;
  logic        inflight_full;
  logic        squash;
  logic        imemresp_val;
  logic        imemresp_rdy;
  logic [31:0] imemresp_data;
  logic        inst_val;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  imm_type;

  int vectors;
  int miscompares;
  int tb_out;

  lab2_proc_fetch_inst_queue #(.NUM_ENTRIES(2), .MAX_INFLIGHT(2)) dut (
    .clk(clk), .reset(reset), .req_fire(req_fire), .req_pc(req_pc),
    .inflight_full(inflight_full), .squash(squash), .imemresp_val(imemresp_val),
    .imemresp_rdy(imemresp_rdy), .imemresp_data(imemresp_data), .inst_val(inst_val),
    .inst_rdy(inst_rdy), .inst(inst), .inst_pc(inst_pc), .imm_type(imm_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment-side outstanding count; a response with nothing outstanding is a protocol error.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_out <= 0;
    else begin
      if (imemresp_val && imemresp_rdy && tb_out == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL protocol: response accepted with outstanding=%0d, need >0", tb_out);
      end
      tb_out <= tb_out + int'(req_fire) - int'(imemresp_val && imemresp_rdy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_fire = 0; req_pc = '0; squash = 0; imemresp_val = 0; imemresp_data = '0;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (inst_val !== 1'b0) begin miscompares++; $display("FAIL rst_inst_val: got %b want 0", inst_val); end
    vectors++; if (inflight_full !== 1'b0) begin miscompares++; $display("FAIL rst_inflight_full: got %b want 0", inflight_full); end
    vectors++; if (imemresp_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_imemresp_rdy: got %b want 1", imemresp_rdy); end
    vectors++; if (inst !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %h want 0", inst); end
    vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
    vectors++; if (imm_type !== 3'd7) begin miscompares++; $display("FAIL rst_imm_type: got %0d want 7", imm_type); end
    #8 reset = 1;
    tick();
  endtask

  task automatic test_basic();
    idle(); inst_rdy = 1;
    req_fire = 1; req_pc = 32'h200; tick();
    req_pc = 32'h204; tick();
    req_fire = 0;
    vectors++; if (inflight_full !== 1'b1) begin miscompares++; $display("FAIL basic_full: got %b want 1", inflight_full); end
    vectors++; if (inst_val !== 1'b0) begin miscompares++; $display("FAIL basic_empty: got %b want 0", inst_val); end
    imemresp_val = 1; imemresp_data = 32'h00500093; #1;
    vectors++; if (imemresp_rdy !== 1'b1) begin miscompares++; $display("FAIL basic_rdy: got %b want 1", imemresp_rdy); end
    tick();
    vectors++; if (inst_val !== 1'b1) begin miscompares++; $display("FAIL basic_val0: got %b want 1", inst_val); end
    vectors++; if (inst !== 32'h00500093) begin miscompares++; $display("FAIL basic_inst0: got %h want 00500093", inst); end
    vectors++; if (inst_pc !== 32'h200) begin miscompares++; $display("FAIL basic_pc0: got %h want 200", inst_pc); end
    vectors++; if (imm_type !== 3'd0) begin miscompares++; $display("FAIL basic_imm0: got %0d want 0", imm_type); end
    vectors++; if (inflight_full !== 1'b0) begin miscompares++; $display("FAIL basic_notfull: got %b want 0", inflight_full); end
    imemresp_data = 32'h0000006F; tick();
    vectors++; if (inst !== 32'h0000006F) begin miscompares++; $display("FAIL basic_inst1: got %h want 0000006f", inst); end
    vectors++; if (inst_pc !== 32'h204) begin miscompares++; $display("FAIL basic_pc1: got %h want 204", inst_pc); end
    vectors++; if (imm_type !== 3'd4) begin miscompares++; $display("FAIL basic_imm1: got %0d want 4", imm_type); end
    imemresp_val = 0; tick();
    vectors++; if (inst_val !== 1'b0) begin miscompares++; $display("FAIL basic_drain: got %b want 0", inst_val); end
  endtask

  task automatic test_backpressure();
    idle(); inst_rdy = 0;
    req_fire = 1; req_pc = 32'h10; tick();
    req_pc = 32'h14; tick();
    req_pc = 32'h18; imemresp_val = 1; imemresp_data = 32'h00000013; tick();
    req_fire = 0; imemresp_data = 32'h00000023; tick();
    imemresp_data = 32'h00000063; #1;
    vectors++; if (imemresp_rdy !== 1'b0) begin miscompares++; $display("FAIL bp_full_rdy: got %b want 0", imemresp_rdy); end
    vectors++; if (inst_pc !== 32'h10) begin miscompares++; $display("FAIL bp_head_pc: got %h want 10", inst_pc); end
    tick();
    inst_rdy = 1; #1;
    vectors++; if (imemresp_rdy !== 1'b0) begin miscompares++; $display("FAIL bp_rdy_indep: got %b want 0", imemresp_rdy); end
    vectors++; if (imm_type !== 3'd0) begin miscompares++; $display("FAIL bp_imm_a: got %0d want 0", imm_type); end
    tick();
    vectors++; if (inst !== 32'h00000023 || inst_pc !== 32'h14) begin miscompares++; $display("FAIL bp_second: got %h@%h want 00000023@14", inst, inst_pc); end
    vectors++; if (imm_type !== 3'd1) begin miscompares++; $display("FAIL bp_imm_b: got %0d want 1", imm_type); end
    vectors++; if (imemresp_rdy !== 1'b1) begin miscompares++; $display("FAIL bp_rdy_reopen: got %b want 1", imemresp_rdy); end
    tick();
    imemresp_val = 0;
    vectors++; if (inst !== 32'h00000063 || inst_pc !== 32'h18) begin miscompares++; $display("FAIL bp_third: got %h@%h want 00000063@18", inst, inst_pc); end
    vectors++; if (imm_type !== 3'd2) begin miscompares++; $display("FAIL bp_imm_c: got %0d want 2", imm_type); end
    tick();
    vectors++; if (inst_val !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", inst_val); end
  endtask

  task automatic test_squash();
    idle(); inst_rdy = 1;
    req_fire = 1; req_pc = 32'h300; tick();
    req_pc = 32'h304; tick();
    req_fire = 0; squash = 1; #1;
    vectors++; if (imemresp_rdy !== 1'b1) begin miscompares++; $display("FAIL sq_rdy: got %b want 1", imemresp_rdy); end
    tick();
    squash = 0; imemresp_val = 1; imemresp_data = 32'h00000013; #1;
    vectors++; if (imemresp_rdy !== 1'b1) begin miscompares++; $display("FAIL sq_drop_rdy: got %b want 1", imemresp_rdy); end
    tick();
    vectors++; if (inst_val !== 1'b0) begin miscompares++; $display("FAIL sq_drop0: got %b want 0", inst_val); end
    tick();
    imemresp_val = 0;
    vectors++; if (inst_val !== 1'b0) begin miscompares++; $display("FAIL sq_drop1: got %b want 0", inst_val); end
    // Redirect target issued in the squash cycle must survive.
    req_fire = 1; req_pc = 32'h300; tick();
    squash = 1; req_pc = 32'h400; tick();
    squash = 0; req_fire = 0; imemresp_val = 1; imemresp_data = 32'h00000037; tick();
    vectors++; if (inst_val !== 1'b0) begin miscompares++; $display("FAIL sq_drop2: got %b want 0", inst_val); end
    imemresp_data = 32'h00C000EF; tick();
    imemresp_val = 0;
    vectors++; if (inst_val !== 1'b1 || inst_pc !== 32'h400) begin miscompares++; $display("FAIL sq_target: got val=%b pc=%h want val=1 pc=400", inst_val, inst_pc); end
    vectors++; if (inst !== 32'h00C000EF || imm_type !== 3'd4) begin miscompares++; $display("FAIL sq_target_inst: got %h/%0d want 00c000ef/4", inst, imm_type); end
    tick();
    vectors++; if (inst_val !== 1'b0) begin miscompares++; $display("FAIL sq_drain: got %b want 0", inst_val); end
  endtask

  task automatic test_squash_full();
    idle(); inst_rdy = 0;
    req_fire = 1; req_pc = 32'hA0; tick();
    req_pc = 32'hA4; tick();
    req_pc = 32'hA8; imemresp_val = 1; imemresp_data = 32'h00000013; tick();
    req_pc = 32'hAC; imemresp_data = 32'h00000023; tick();
    req_fire = 0; imemresp_data = 32'hDEADBEEF; #1;
    vectors++; if (imemresp_rdy !== 1'b0 || inflight_full !== 1'b1) begin miscompares++; $display("FAIL sqf_pre: got rdy=%b full=%b want rdy=0 full=1", imemresp_rdy, inflight_full); end
    squash = 1; inst_rdy = 1; #1;
    vectors++; if (imemresp_rdy !== 1'b1) begin miscompares++; $display("FAIL sqf_rdy_forced: got %b want 1", imemresp_rdy); end
    tick();
    squash = 0;
    vectors++; if (inst_val !== 1'b0) begin miscompares++; $display("FAIL sqf_flush: got %b want 0", inst_val); end
    imemresp_data = 32'h00000013; tick();
    imemresp_val = 0;
    vectors++; if (inst_val !== 1'b0) begin miscompares++; $display("FAIL sqf_drop: got %b want 0", inst_val); end
    req_fire = 1; req_pc = 32'hB0; tick();
    req_fire = 0; imemresp_val = 1; imemresp_data = 32'h00000017; tick();
    imemresp_val = 0;
    vectors++; if (inst_val !== 1'b1 || inst_pc !== 32'hB0 || imm_type !== 3'd3) begin miscompares++; $display("FAIL sqf_keep: got val=%b pc=%h imm=%0d want 1/b0/3", inst_val, inst_pc, imm_type); end
    tick();
    vectors++; if (inst_val !== 1'b0) begin miscompares++; $display("FAIL sqf_drain: got %b want 0", inst_val); end
  endtask

  task automatic test_inflight();
    idle(); inst_rdy = 1;
    req_fire = 1; req_pc = 32'h40; tick();
    req_pc = 32'h44; tick();
    vectors++; if (inflight_full !== 1'b1) begin miscompares++; $display("FAIL if_full: got %b want 1", inflight_full); end
    req_pc = 32'h48; imemresp_val = 1; imemresp_data = 32'h00000013; tick();
    req_fire = 0;
    vectors++; if (inflight_full !== 1'b1) begin miscompares++; $display("FAIL if_hold: got %b want 1", inflight_full); end
    vectors++; if (inst_pc !== 32'h40) begin miscompares++; $display("FAIL if_pc0: got %h want 40", inst_pc); end
    imemresp_data = 32'h00000003; tick();
    vectors++; if (inflight_full !== 1'b0) begin miscompares++; $display("FAIL if_release: got %b want 0", inflight_full); end
    vectors++; if (inst_pc !== 32'h44 || imm_type !== 3'd0) begin miscompares++; $display("FAIL if_pc1: got %h/%0d want 44/0", inst_pc, imm_type); end
    imemresp_data = 32'h0000007F; tick();
    imemresp_val = 0;
    vectors++; if (inst_pc !== 32'h48 || imm_type !== 3'd7) begin miscompares++; $display("FAIL if_pc2: got %h/%0d want 48/7", inst_pc, imm_type); end
    tick();
    vectors++; if (inst_val !== 1'b0 || imm_type !== 3'd7) begin miscompares++; $display("FAIL if_drain: got val=%b imm=%0d want 0/7", inst_val, imm_type); end
  endtask

  task automatic test_async_reset();
    idle(); inst_rdy = 0;
    req_fire = 1; req_pc = 32'hC0; tick();
    req_pc = 32'hC4; tick();
    req_pc = 32'hC8; imemresp_val = 1; imemresp_data = 32'h00000013; tick();
    req_pc = 32'hCC; imemresp_data = 32'h00000023; tick();
    idle();
    vectors++; if (inst_val !== 1'b1 || inflight_full !== 1'b1) begin miscompares++; $display("FAIL ar_pre: got val=%b full=%b want 1/1", inst_val, inflight_full); end
    #2 reset = 0; #1;
    vectors++; if (inst_val !== 1'b0 || inflight_full !== 1'b0) begin miscompares++; $display("FAIL ar_clear: got val=%b full=%b want 0/0", inst_val, inflight_full); end
    vectors++; if (imemresp_rdy !== 1'b1 || inst !== 32'h0 || imm_type !== 3'd7) begin miscompares++; $display("FAIL ar_outs: got rdy=%b inst=%h imm=%0d want 1/0/7", imemresp_rdy, inst, imm_type); end
    reset = 1; tick();
    // Pending drop count must not survive a reset.
    req_fire = 1; req_pc = 32'hE0; tick();
    req_fire = 0; squash = 1; tick();
    squash = 0; #2 reset = 0; #1 reset = 1;
    vectors++; if (inflight_full !== 1'b0 || imemresp_rdy !== 1'b1) begin miscompares++; $display("FAIL ar2_clear: got full=%b rdy=%b want 0/1", inflight_full, imemresp_rdy); end
    tick();
    inst_rdy = 1; req_fire = 1; req_pc = 32'hF0; tick();
    req_fire = 0; imemresp_val = 1; imemresp_data = 32'h00000013; tick();
    imemresp_val = 0;
    vectors++; if (inst_val !== 1'b1 || inst_pc !== 32'hF0) begin miscompares++; $display("FAIL ar2_kept: got val=%b pc=%h want 1/f0", inst_val, inst_pc); end
    tick();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 0; inst_rdy = 0;
    idle();
    test_reset();
    test_basic();
    test_backpressure();
    test_squash();
    test_squash_full();
    test_inflight();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
